// File: rtl/fetch_queue_unit_pkg.sv
// Shared widths and FSM encoding for the fetch queue front end.
package fetch_queue_unit_pkg;

  localparam int FQ_ADDR_LEN = 32;
  localparam int FQ_INSN_LEN = 32;

  typedef enum logic [1:0] {
    FQ_FETCH = 2'd0,
    FQ_WAIT  = 2'd1,
    FQ_DROP  = 2'd2
  } fq_state_e;

endpackage

// File: rtl/fetch_queue_unit_aligner.sv
// Shifts a returned imem line down by the PC word offset and produces
// the PC of every surviving word plus how many words survive.
module fetch_line_aligner #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_LEN   = 32,
  parameter int INSN_LEN   = 32
) (
  input  logic [LINE_WORDS*INSN_LEN-1:0]      line_i,
  input  logic [$clog2(LINE_WORDS)-1:0]       off_i,
  input  logic [ADDR_LEN-1:0]                 base_addr_i,
  output logic [LINE_WORDS*INSN_LEN-1:0]      words_o,
  output logic [LINE_WORDS*ADDR_LEN-1:0]      pcs_o,
  output logic [$clog2(LINE_WORDS+1)-1:0]     count_o
);

  localparam int CNT_W = $clog2(LINE_WORDS + 1);

  int src;

  always_comb begin
    words_o = '0;
    pcs_o   = '0;
    src     = 0;
    for (int j = 0; j < LINE_WORDS; j++) begin
      src = int'(off_i) + j;
      if (src < LINE_WORDS) begin
        words_o[j*INSN_LEN +: INSN_LEN] = line_i[src*INSN_LEN +: INSN_LEN];
        pcs_o[j*ADDR_LEN +: ADDR_LEN]   = base_addr_i + ADDR_LEN'(src * 4);
      end
    end
    count_o = CNT_W'(LINE_WORDS - int'(off_i));
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: owns the fetch PC, issues one line request at a time and
// buffers aligned words with their PCs in a circular queue feeding decode.
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int                ADDR_LEN   = FQ_ADDR_LEN,
  parameter int                INSN_LEN   = FQ_INSN_LEN,
  parameter int                LINE_WORDS = 4,
  parameter int                QDEPTH     = 8,
  parameter int                OUT_WIDTH  = 2,
  parameter logic [ADDR_LEN-1:0] RESET_PC = '0
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               redirect_valid_i,
  input  logic [ADDR_LEN-1:0]                redirect_pc_i,
  output logic                               imem_req_o,
  output logic [ADDR_LEN-1:0]                imem_addr_o,
  input  logic                               imem_ready_i,
  input  logic                               imem_rvalid_i,
  input  logic [LINE_WORDS*INSN_LEN-1:0]     idata_i,
  output logic [OUT_WIDTH-1:0]               out_valid_o,
  output logic [OUT_WIDTH*INSN_LEN-1:0]      out_inst_o,
  output logic [OUT_WIDTH*ADDR_LEN-1:0]      out_pc_o,
  input  logic [$clog2(OUT_WIDTH+1)-1:0]     deq_count_i
);

  localparam int LW_BITS = $clog2(LINE_WORDS);
  localparam int PTR_W   = $clog2(QDEPTH);
  localparam int OCC_W   = PTR_W + 1;
  localparam int CNT_W   = $clog2(LINE_WORDS + 1);
  localparam logic [ADDR_LEN-1:0] ALIGN_MASK = ADDR_LEN'((64'd1 << (LW_BITS + 2)) - 64'd1);
  localparam logic [ADDR_LEN-1:0] LINE_BYTES = ADDR_LEN'(LINE_WORDS * 4);

  fq_state_e             state_q, state_d;
  logic [ADDR_LEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [OCC_W-1:0]      occ_q, occ_d;

  logic [INSN_LEN-1:0]   inst_mem [QDEPTH];
  logic [ADDR_LEN-1:0]   pc_mem   [QDEPTH];

  logic [ADDR_LEN-1:0]               aligned_addr;
  logic [LW_BITS-1:0]                off;
  logic [LINE_WORDS*INSN_LEN-1:0]    al_words;
  logic [LINE_WORDS*ADDR_LEN-1:0]    al_pcs;
  logic [CNT_W-1:0]                  al_count;
  logic                              space_ok;
  logic                              push_en;

  assign aligned_addr = fetch_pc_q & ~ALIGN_MASK;
  assign off          = fetch_pc_q[LW_BITS+1:2];
  assign imem_addr_o  = aligned_addr;
  assign space_ok     = (QDEPTH - int'(occ_q)) >= LINE_WORDS;
  assign imem_req_o   = !reset_i && (state_q == FQ_FETCH) && space_ok && !redirect_valid_i;
  assign push_en      = (state_q == FQ_WAIT) && imem_rvalid_i && !redirect_valid_i;

  fetch_line_aligner #(
    .LINE_WORDS (LINE_WORDS),
    .ADDR_LEN   (ADDR_LEN),
    .INSN_LEN   (INSN_LEN)
  ) u_aligner (
    .line_i      (idata_i),
    .off_i       (off),
    .base_addr_i (aligned_addr),
    .words_o     (al_words),
    .pcs_o       (al_pcs),
    .count_o     (al_count)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q + PTR_W'(deq_count_i);
    tail_d     = tail_q;
    occ_d      = occ_q - OCC_W'(deq_count_i);
    if (push_en) begin
      tail_d = tail_q + PTR_W'(al_count);
      occ_d  = occ_d + OCC_W'(al_count);
    end
    case (state_q)
      FQ_FETCH: if (imem_req_o && imem_ready_i) state_d = FQ_WAIT;
      FQ_WAIT: begin
        if (push_en) begin
          fetch_pc_d = aligned_addr + LINE_BYTES;
          state_d    = FQ_FETCH;
        end
      end
      FQ_DROP: if (imem_rvalid_i) state_d = FQ_FETCH;
      default: state_d = FQ_FETCH;
    endcase
    // A line arriving with the redirect is the outstanding one, so only a
    // still-pending response has to be dropped later.
    if (redirect_valid_i) begin
      head_d     = '0;
      tail_d     = '0;
      occ_d      = '0;
      fetch_pc_d = redirect_pc_i;
      state_d    = ((state_q == FQ_WAIT || state_q == FQ_DROP) && !imem_rvalid_i)
                   ? FQ_DROP : FQ_FETCH;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= FQ_FETCH;
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) begin
      for (int j = 0; j < LINE_WORDS; j++) begin
        if (CNT_W'(j) < al_count) begin
          inst_mem[tail_q + PTR_W'(j)] <= al_words[j*INSN_LEN +: INSN_LEN];
          pc_mem[tail_q + PTR_W'(j)]   <= al_pcs[j*ADDR_LEN +: ADDR_LEN];
        end
      end
    end
  end

  always_comb begin
    out_valid_o = '0;
    out_inst_o  = '0;
    out_pc_o    = '0;
    for (int k = 0; k < OUT_WIDTH; k++) begin
      out_valid_o[k]                   = occ_q > OCC_W'(k);
      out_inst_o[k*INSN_LEN +: INSN_LEN] = inst_mem[head_q + PTR_W'(k)];
      out_pc_o[k*ADDR_LEN +: ADDR_LEN]   = pc_mem[head_q + PTR_W'(k)];
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: a transaction-level fetch model
// predicts queue contents and request behaviour under directed and random traffic.
module tb_fetch_queue_unit;

  localparam int          LW  = 4;
  localparam int          QD  = 8;
  localparam int          OW  = 2;
  localparam logic [31:0] RPC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  logic           clk_i;
  logic           reset_i;
  logic           redirect_valid_i;
  logic [31:0]    redirect_pc_i;
  logic           imem_req_o;
  logic [31:0]    imem_addr_o;
  logic           imem_ready_i;
  logic           imem_rvalid_i;
  logic [LW*32-1:0] idata_i;
  logic [OW-1:0]  out_valid_o;
  logic [OW*32-1:0] out_inst_o;
  logic [OW*32-1:0] out_pc_o;
  logic [1:0]     deq_count_i;

  // Model: words waiting for decode, plus whether a line request is in
  // flight and whether its response has been made stale by a redirect.
  ent_t        exp_q[$];
  bit          m_busy;
  bit          m_drop;
  logic [31:0] m_pc;
  int          checks;
  int          errors;

  fetch_queue_unit #(
    .ADDR_LEN   (32),
    .INSN_LEN   (32),
    .LINE_WORDS (LW),
    .QDEPTH     (QD),
    .OUT_WIDTH  (OW),
    .RESET_PC   (RPC)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_ready_i     (imem_ready_i),
    .imem_rvalid_i    (imem_rvalid_i),
    .idata_i          (idata_i),
    .out_valid_o      (out_valid_o),
    .out_inst_o       (out_inst_o),
    .out_pc_o         (out_pc_o),
    .deq_count_i      (deq_count_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    redirect_valid_i = 1'b0;
    redirect_pc_i    = '0;
    imem_ready_i     = 1'b0;
    imem_rvalid_i    = 1'b0;
    idata_i          = '0;
    deq_count_i      = '0;
  endtask

  // One clock cycle of stimulus; request behaviour is checked before the
  // edge and the model advances on the edge.
  task automatic applyStimulus(input bit redir, input logic [31:0] rpc, input bit rdy,
                               input bit rv, input logic [LW*32-1:0] line, input int deq);
    int          occ;
    int          off;
    bit          exp_req;
    logic [31:0] aligned;
    ent_t        e;
    @(negedge clk_i);
    redirect_valid_i = redir;
    redirect_pc_i    = rpc;
    imem_ready_i     = rdy;
    imem_rvalid_i    = rv;
    idata_i          = line;
    deq_count_i      = 2'(deq);
    occ     = exp_q.size();
    exp_req = !m_busy && (QD - occ >= LW) && !redir;
    aligned = m_pc - (m_pc % 32'(LW * 4));
    #1;
    checkOutput("imem_req", 64'(imem_req_o), 64'(exp_req));
    if (exp_req) checkOutput("imem_addr", 64'(imem_addr_o), 64'(aligned));
    checks++;
    if (deq > $countones(out_valid_o)) begin
      errors++;
      $display("[TB] FAIL deq_legal: deq %0d valid %b", deq, out_valid_o);
    end
    @(posedge clk_i);
    if (redir) begin
      exp_q.delete();
      m_pc = rpc;
      if (m_busy) begin
        if (rv) begin
          m_busy = 1'b0;
          m_drop = 1'b0;
        end else begin
          m_drop = 1'b1;
        end
      end
    end else if (!m_busy) begin
      if (exp_req && rdy) m_busy = 1'b1;
    end else if (rv) begin
      if (!m_drop) begin
        off = int'((m_pc % 32'(LW * 4)) / 32'd4);
        for (int k = off; k < LW; k++) begin
          e.inst = line[k*32 +: 32];
          e.pc   = aligned + 32'(4 * k);
          exp_q.push_back(e);
        end
        m_pc = aligned + 32'(LW * 4);
      end
      m_busy = 1'b0;
      m_drop = 1'b0;
    end
    #1;
    idleInputs();
  endtask

  // Monitor: compares every presented slot with the scoreboard head and
  // retires whatever decode consumes this cycle.
  always @(negedge clk_i) begin : monitor
    int         n;
    logic [1:0] ev;
    ent_t       e;
    #2;
    if (!reset_i) begin
      n  = (exp_q.size() < OW) ? exp_q.size() : OW;
      ev = '0;
      for (int k = 0; k < OW; k++) if (k < n) ev[k] = 1'b1;
      checks++;
      if (out_valid_o !== ev) begin
        errors++;
        $display("[TB] FAIL out_valid: got %b expected %b", out_valid_o, ev);
      end
      for (int k = 0; k < n; k++) begin
        e = exp_q[k];
        checks++;
        if (out_inst_o[k*32 +: 32] !== e.inst || out_pc_o[k*32 +: 32] !== e.pc) begin
          errors++;
          $display("[TB] FAIL slot%0d: got %h@%h expected %h@%h", k,
                   out_inst_o[k*32 +: 32], out_pc_o[k*32 +: 32], e.inst, e.pc);
        end
      end
      for (int k = 0; k < int'(deq_count_i); k++)
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  function automatic logic [LW*32-1:0] mkLine(input logic [31:0] w0, input logic [31:0] w1,
                                              input logic [31:0] w2, input logic [31:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  initial begin
    bit          redir;
    bit          rdy;
    bit          rv;
    int          deq;
    int          lim;
    logic [31:0] rpc;
    checks  = 0;
    errors  = 0;
    m_busy  = 1'b0;
    m_drop  = 1'b0;
    m_pc    = RPC;
    reset_i = 1'b1;
    idleInputs();
    #1;
    checkOutput("reset_req", 64'(imem_req_o), 64'd0);
    checkOutput("reset_valid", 64'(out_valid_o), 64'd0);
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;

    // Straight-line fetch from the reset PC, then drain.
    applyStimulus(0, 0, 1, 0, '0, 0);
    applyStimulus(0, 0, 0, 1, mkLine(32'h11, 32'h22, 32'h33, 32'h44), 0);
    checkOutput("t1_slot0", {out_inst_o[31:0], out_pc_o[31:0]}, {32'h11, 32'h8000_0000});
    checkOutput("t1_slot1", {out_inst_o[63:32], out_pc_o[63:32]}, {32'h22, 32'h8000_0004});
    checkOutput("t1_next_addr", 64'(imem_addr_o), 64'h8000_0010);
    applyStimulus(0, 0, 0, 0, '0, 2);
    checkOutput("t1_slot0b", {out_inst_o[31:0], out_pc_o[31:0]}, {32'h33, 32'h8000_0008});
    checkOutput("t1_slot1b", {out_inst_o[63:32], out_pc_o[63:32]}, {32'h44, 32'h8000_000C});
    applyStimulus(0, 0, 0, 0, '0, 2);

    // Redirect into the middle of a line.
    applyStimulus(1, 32'h8000_0108, 1, 0, '0, 0);
    applyStimulus(0, 0, 1, 0, '0, 0);
    applyStimulus(0, 0, 0, 1, mkLine(32'hA0, 32'hA1, 32'hA2, 32'hA3), 0);
    checkOutput("t2_valid", 64'(out_valid_o), 64'h3);
    checkOutput("t2_slot0", {out_inst_o[31:0], out_pc_o[31:0]}, {32'hA2, 32'h8000_0108});
    checkOutput("t2_slot1", {out_inst_o[63:32], out_pc_o[63:32]}, {32'hA3, 32'h8000_010C});
    checkOutput("t2_next_addr", 64'(imem_addr_o), 64'h8000_0110);
    applyStimulus(0, 0, 0, 0, '0, 2);

    // Fill the queue and watch the space check throttle requests.
    applyStimulus(0, 0, 1, 0, '0, 0);
    applyStimulus(0, 0, 0, 1, mkLine(32'hC0, 32'hC1, 32'hC2, 32'hC3), 0);
    applyStimulus(0, 0, 1, 0, '0, 0);
    applyStimulus(0, 0, 0, 1, mkLine(32'hC4, 32'hC5, 32'hC6, 32'hC7), 0);
    checkOutput("t3_req_full", 64'(imem_req_o), 64'd0);
    applyStimulus(0, 0, 0, 0, '0, 2);
    checkOutput("t3_req_six", 64'(imem_req_o), 64'd0);
    applyStimulus(0, 0, 0, 0, '0, 2);
    checkOutput("t3_req_four", 64'(imem_req_o), 64'd1);

    // Redirect while a response is outstanding; the late line is dropped.
    applyStimulus(0, 0, 1, 0, '0, 0);
    applyStimulus(1, 32'h8000_0204, 0, 0, '0, 0);
    applyStimulus(0, 0, 0, 1, {4{32'hFFFF_FFFF}}, 0);
    checkOutput("t4_empty", 64'(out_valid_o), 64'd0);
    applyStimulus(0, 0, 1, 0, '0, 0);
    applyStimulus(0, 0, 0, 1, mkLine(32'hB0, 32'hB1, 32'hB2, 32'hB3), 0);
    checkOutput("t4_slot0", {out_inst_o[31:0], out_pc_o[31:0]}, {32'hB1, 32'h8000_0204});
    applyStimulus(0, 0, 0, 0, '0, 2);
    applyStimulus(0, 0, 0, 0, '0, 1);

    // Push and pop in the same cycle across the end of the storage.
    applyStimulus(1, 32'h8000_0300, 0, 0, '0, 0);
    applyStimulus(0, 0, 1, 0, '0, 0);
    applyStimulus(0, 0, 0, 1, mkLine(32'hD0, 32'hD1, 32'hD2, 32'hD3), 0);
    applyStimulus(0, 0, 0, 0, '0, 2);
    applyStimulus(0, 0, 0, 0, '0, 2);
    applyStimulus(0, 0, 1, 0, '0, 0);
    applyStimulus(0, 0, 0, 1, mkLine(32'hD4, 32'hD5, 32'hD6, 32'hD7), 0);
    applyStimulus(0, 0, 0, 0, '0, 2);
    applyStimulus(0, 0, 1, 0, '0, 0);
    applyStimulus(0, 0, 0, 1, mkLine(32'hD8, 32'hD9, 32'hDA, 32'hDB), 2);
    checkOutput("t5_slot0", {out_inst_o[31:0], out_pc_o[31:0]}, {32'hD8, 32'h8000_0320});
    checkOutput("t5_slot1", {out_inst_o[63:32], out_pc_o[63:32]}, {32'hD9, 32'h8000_0324});
    applyStimulus(0, 0, 0, 0, '0, 2);
    checkOutput("t5_slot0b", {out_inst_o[31:0], out_pc_o[31:0]}, {32'hDA, 32'h8000_0328});

    // Asynchronous reset in the middle of a WAIT cycle.
    applyStimulus(0, 0, 1, 0, '0, 0);
    @(negedge clk_i);
    #3;
    reset_i = 1'b1;
    #1;
    checkOutput("t6_req", 64'(imem_req_o), 64'd0);
    checkOutput("t6_valid", 64'(out_valid_o), 64'd0);
    exp_q.delete();
    m_busy = 1'b0;
    m_drop = 1'b0;
    m_pc   = RPC;
    @(negedge clk_i);
    reset_i = 1'b0;
    applyStimulus(0, 0, 1, 1, {4{32'hDEAD_BEEF}}, 0);
    applyStimulus(0, 0, 0, 1, mkLine(32'hE0, 32'hE1, 32'hE2, 32'hE3), 0);
    checkOutput("t6_slot0", {out_inst_o[31:0], out_pc_o[31:0]}, {32'hE0, 32'h8000_0000});

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rdy   = ($urandom_range(0, 1) == 1);
      rv    = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      redir = ($urandom_range(0, 15) == 0);
      if (m_busy && !m_drop && rv) redir = 1'b0;
      rpc   = $urandom;
      lim   = (exp_q.size() < OW) ? exp_q.size() : OW;
      deq   = $urandom_range(0, lim);
      applyStimulus(redir, rpc, rdy, rv, {$urandom, $urandom, $urandom, $urandom}, deq);
    end

    @(negedge clk_i);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
